// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle for alu_mc.
//
// Handshake rules (both channels):
//   - A transfer happens on a rising clk edge where valid && ready are both 1.
//   - The producer holds its payload stable while valid && !ready.
//   - ready may depend combinationally on the consumer's state, never on valid.
//
// Signals:
//   in_valid / in_ready       operand channel (issue stage -> alu_mc)
//   a, b [WIDTH], sel [4]     operands and opcode
//   out_valid / out_ready     result channel (alu_mc -> writeback)
//   result [2*WIDTH]          result, zero-extended for non-multiply ops
//   carry, overflow, zero, negative   flags registered with result
//
// Modports: master = issue/writeback side, slave = alu_mc.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 carry;
  logic                 overflow;
  logic                 zero;
  logic                 negative;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero, negative
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with valid/ready handshakes.
//
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR, EQ, LTU, illegal) load
// the output register on the accept edge. MUL runs an iterative shift-add
// unsigned multiplier for WIDTH cycles and then loads the full product.
// One operation is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   bus        alu_mc_if.slave (operand and result channels, see interface)
//   dbg_state  current FSM state (IDLE=0, MUL=1, HOLD=2) for observation
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  alu_mc_if.slave     bus,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_LTU = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t state, state_next;

  // Output register
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 carry_q;
  logic                 overflow_q;
  logic                 zero_q;
  logic                 negative_q;

  // Multiplier datapath
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   a_shift;
  logic [WIDTH-1:0]     b_shift;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   mul_prod;
  logic                 last_step;

  // Control
  logic                 out_free;
  logic                 rdy;
  logic                 load_alu;
  logic                 load_mul;
  logic                 mul_start;

  // Single-cycle ALU
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;

  // The output register can take a new value when it is empty or being
  // consumed on this same edge.
  assign out_free  = !out_valid_q || bus.out_ready;
  assign last_step = (cnt == CW'(WIDTH - 1));

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign step_acc  = acc + (b_shift[0] ? a_shift : '0);

  // In MUL the product is completed by the step happening on this very edge;
  // in HOLD it was already stored in acc.
  assign mul_prod  = (state == ST_MUL) ? step_acc : acc;

  //--------------------------------------------------------------------------
  // Combinational ALU for every opcode except MUL
  //--------------------------------------------------------------------------
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        // The extra top bit of the widened subtraction is the borrow (a < b).
        alu_c   = diff[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res = {bus.a[WIDTH-2:0], 1'b0};
        alu_c   = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, bus.a[WIDTH-1:1]};
        alu_c   = bus.a[0];
      end
      OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      OP_LTU: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default: begin
        // Illegal opcodes (and MUL, which never loads from here) give 0.
        alu_res = '0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state and control strobes
  //--------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    rdy        = 1'b0;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    mul_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy = out_free;
        if (bus.in_valid && rdy) begin
          if (bus.sel == OP_MUL) begin
            mul_start  = 1'b1;
            state_next = ST_MUL;
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (last_step) begin
          if (out_free) begin
            load_mul   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          load_mul   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Multiplier registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      a_shift <= '0;
      b_shift <= '0;
      cnt     <= '0;
    end else if (mul_start) begin
      acc     <= '0;
      a_shift <= {{WIDTH{1'b0}}, bus.a};
      b_shift <= bus.b;
      cnt     <= '0;
    end else if (state == ST_MUL) begin
      // The final step also lands in acc so HOLD can deliver it later.
      acc     <= step_acc;
      a_shift <= {a_shift[2*WIDTH-2:0], 1'b0};
      b_shift <= {1'b0, b_shift[WIDTH-1:1]};
      cnt     <= cnt + 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Output register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
    end else if (load_alu) begin
      out_valid_q <= 1'b1;
      result_q    <= {{WIDTH{1'b0}}, alu_res};
      carry_q     <= alu_c;
      overflow_q  <= alu_v;
      zero_q      <= (alu_res == '0);
      negative_q  <= alu_res[WIDTH-1];
    end else if (load_mul) begin
      out_valid_q <= 1'b1;
      result_q    <= mul_prod;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= (mul_prod == '0);
      negative_q  <= mul_prod[2*WIDTH-1];
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=8).
// Directed vector table, hand-written handshake/reset sequences and random
// operations checked against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  //--------------------------------------------------------------------------
  // Clock / reset
  //--------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  //--------------------------------------------------------------------------
  // Scoreboard bookkeeping
  //--------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    int          lat;
    int          busy;
  } vec_t;

  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model from the opcode rules, using integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int sel);
    exp_t e;
    int   r, sa, sb, s, c, v;
    r = 0; c = 0; v = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (sel)
      0: begin r = (a + b) % 256; c = (a + b >= 256); s = sa + sb; v = (s > 127 || s < -128); end
      1: begin r = (a - b + 256) % 256; c = (a < b); s = sa - sb; v = (s > 127 || s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 256; c = (a >= 128); end
      6: begin r = a / 2; c = a % 2; end
      7: r = (a == b) ? 1 : 0;
      8: r = a * b;
      9: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    e.res = 16'(r);
    e.c   = (c != 0);
    e.v   = (v != 0);
    e.z   = (r == 0);
    e.n   = (sel == 8) ? (r >= 32768) : (r >= 128);
    return e;
  endfunction

  //--------------------------------------------------------------------------
  // Driver: issue one op with out_ready=1, wait for its result.
  // Called and returning #1 after a rising edge.
  //--------------------------------------------------------------------------
  task automatic run_op(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                        output exp_t got, output int lat, output int busy);
    int guard;
    guard = 0;
    bus.out_ready = 1'b1;
    #1;
    while (!bus.in_ready && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    bus.a = a; bus.b = b; bus.sel = sel; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble the operands: the block must use its own copies.
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.sel = 4'($urandom);
    lat = 1; busy = 0;
    while (!bus.out_valid && lat < 30) begin
      if (!bus.in_ready) busy++;
      @(posedge clk); #1; lat++;
    end
    got.res = bus.result; got.c = bus.carry; got.v = bus.overflow;
    got.z = bus.zero; got.n = bus.negative;
  endtask

  // Let any pending result drain so the output register is empty.
  task automatic drain();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs[14];

  initial begin
    exp_t got, e;
    int   lat, busy;
    logic seen;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.out_ready = 1'b1;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_result",    bus.result,    0);
    check("rst_flags", {bus.carry, bus.overflow, bus.zero, bus.negative}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //------------------------------------------------------------------------
    // Directed vector table
    //------------------------------------------------------------------------
    vecs[0]  = '{4'd0,  8'd200, 8'd100, 16'h002C, 1, 0, 0, 0, 1, 0};
    vecs[1]  = '{4'd1,  8'd5,   8'd7,   16'h00FE, 1, 0, 0, 1, 1, 0};
    vecs[2]  = '{4'd1,  8'h80,  8'h01,  16'h007F, 0, 1, 0, 0, 1, 0};
    vecs[3]  = '{4'd8,  8'hFF,  8'hFF,  16'hFE01, 0, 0, 0, 1, 9, 8};
    vecs[4]  = '{4'd15, 8'h3C,  8'hA5,  16'h0000, 0, 0, 1, 0, 1, 0};
    vecs[5]  = '{4'd5,  8'h81,  8'h00,  16'h0002, 1, 0, 0, 0, 1, 0};
    vecs[6]  = '{4'd6,  8'h81,  8'h00,  16'h0040, 1, 0, 0, 0, 1, 0};
    vecs[7]  = '{4'd7,  8'h5A,  8'h5A,  16'h0001, 0, 0, 0, 0, 1, 0};
    vecs[8]  = '{4'd9,  8'h03,  8'h04,  16'h0001, 0, 0, 0, 0, 1, 0};
    vecs[9]  = '{4'd2,  8'hF0,  8'h3C,  16'h0030, 0, 0, 0, 0, 1, 0};
    vecs[10] = '{4'd3,  8'hF0,  8'h0F,  16'h00FF, 0, 0, 0, 1, 1, 0};
    vecs[11] = '{4'd4,  8'hAA,  8'hAA,  16'h0000, 0, 0, 1, 0, 1, 0};
    vecs[12] = '{4'd0,  8'h7F,  8'h01,  16'h0080, 0, 1, 0, 1, 1, 0};
    vecs[13] = '{4'd8,  8'h00,  8'hFF,  16'h0000, 0, 0, 1, 0, 9, 8};

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, got, lat, busy);
      check($sformatf("vec%0d_result", i),   got.res, vecs[i].res);
      check($sformatf("vec%0d_carry", i),    got.c,   vecs[i].c);
      check($sformatf("vec%0d_overflow", i), got.v,   vecs[i].v);
      check($sformatf("vec%0d_zero", i),     got.z,   vecs[i].z);
      check($sformatf("vec%0d_negative", i), got.n,   vecs[i].n);
      check($sformatf("vec%0d_latency", i),  lat,     vecs[i].lat);
      check($sformatf("vec%0d_busy", i),     busy,    vecs[i].busy);
    end

    //------------------------------------------------------------------------
    // Back-pressure: ADD held, queued XOR accepted on the consume edge
    //------------------------------------------------------------------------
    drain();
    bus.out_ready = 1'b0;
    #1;
    check("bp_in_ready_empty", bus.in_ready, 1);
    bus.a = 8'd1; bus.b = 8'd1; bus.sel = 4'd0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'hF0; bus.b = 8'h0F; bus.sel = 4'd4;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold%0d_valid", k),  bus.out_valid, 1);
      check($sformatf("bp_hold%0d_result", k), bus.result,    16'h0002);
      check($sformatf("bp_hold%0d_ready", k),  bus.in_ready,  0);
      if (k < 2) begin @(posedge clk); #1; end
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_xor_valid",  bus.out_valid, 1);
    check("bp_xor_result", bus.result,    16'h00FF);
    @(posedge clk); #1;
    check("bp_consumed", bus.out_valid, 0);

    //------------------------------------------------------------------------
    // MUL completing into a stalled consumer: product held stable
    //------------------------------------------------------------------------
    drain();
    bus.out_ready = 1'b0;
    bus.a = 8'd13; bus.b = 8'd11; bus.sel = 4'd8; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    check("mulbp_latency", lat, 9);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mulbp%0d_result", k), bus.result,   16'd143);
      check($sformatf("mulbp%0d_ready", k),  bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("mulbp_consumed", bus.out_valid, 0);

    //------------------------------------------------------------------------
    // Reset in the middle of a multiply
    //------------------------------------------------------------------------
    drain();
    bus.a = 8'hFF; bus.b = 8'hFF; bus.sel = 4'd8; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midmul_busy", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready",  bus.in_ready,  1);
    check("midrst_result",    bus.result,    0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst_discarded", seen, 0);
    run_op(4'd7, 8'h5A, 8'h5A, got, lat, busy);
    check("post_rst_eq_result", got.res, 16'h0001);
    check("post_rst_eq_zero",   got.z,   0);

    //------------------------------------------------------------------------
    // Random operations vs. reference model
    //------------------------------------------------------------------------
    for (int i = 0; i < 250; i++) begin
      logic [3:0] s;
      logic [7:0] ra, rb;
      s  = 4'($urandom_range(0, 15));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      e  = model(int'(ra), int'(rb), int'(s));
      exp_q.push_back(ra);
      run_op(s, ra, rb, got, lat, busy);
      check($sformatf("rnd%0d_sel%0d_result", i, s), got.res, e.res);
      check($sformatf("rnd%0d_flags", i), {got.c, got.v, got.z, got.n}, {e.c, e.v, e.z, e.n});
      check($sformatf("rnd%0d_latency", i), lat, (s == 4'd8) ? 9 : 1);
      void'(exp_q.pop_front());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
